// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader drives the write bus and byte_ready, so it takes the master side.
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes NUM_WORDS of them from BASE_ADDR while holding the CPU.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_WORDS = 256
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 abort,
   imem_loader_if.master        bus,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          words_loaded
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t             state;
   logic [1:0]         byte_cnt;
   logic [23:0]        asm_word;
   logic [CNT_W-1:0]   wl_next;
   logic [ADDR_W-1:0]  word_addr;

   assign wl_next   = words_loaded + CNT_W'(1);
   assign word_addr = BASE_ADDR + {14'd0, words_loaded, 2'b00};

   // Single registered FSM; every output is a flop updated alongside the state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         byte_cnt       <= 2'd0;
         asm_word       <= 24'd0;
         words_loaded   <= '0;
         bus.byte_ready <= 1'b0;
         bus.wr_en      <= 1'b0;
         bus.wr_addr    <= '0;
         bus.wr_data    <= '0;
         cpu_hold       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= LOAD;
                  byte_cnt       <= 2'd0;
                  words_loaded   <= '0;
                  done           <= 1'b0;
                  busy           <= 1'b1;
                  cpu_hold       <= 1'b1;
                  bus.byte_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (abort) begin
                  state          <= IDLE;
                  busy           <= 1'b0;
                  cpu_hold       <= 1'b0;
                  bus.byte_ready <= 1'b0;
               end else if (bus.byte_valid) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_word[7:0]   <= bus.byte_data;
                     2'd1: asm_word[15:8]  <= bus.byte_data;
                     2'd2: asm_word[23:16] <= bus.byte_data;
                     default: begin
                        // Fourth byte completes the word; issue the write next cycle.
                        state          <= WRITE;
                        bus.byte_ready <= 1'b0;
                        bus.wr_en      <= 1'b1;
                        bus.wr_addr    <= word_addr;
                        bus.wr_data    <= {bus.byte_data, asm_word};
                     end
                  endcase
               end
            end
            WRITE: begin
               // The write on the bus this cycle always lands, even under abort.
               words_loaded <= wl_next;
               byte_cnt     <= 2'd0;
               if (abort) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
               end else if (wl_next == CNT_W'(NUM_WORDS)) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
               end else begin
                  state          <= LOAD;
                  bus.byte_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: four parameterisations share one stimulus
// stream; each scenario resets all of them and observes the selected one.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        abort;
   logic        byte_valid;
   logic [7:0]  byte_data;

   imem_loader_if i0 ();
   imem_loader_if i1 ();
   imem_loader_if i2 ();
   imem_loader_if i3 ();

   logic        hold_v [4];
   logic        busy_v [4];
   logic        done_v [4];
   logic [15:0] wl_v   [4];

   assign i0.byte_valid = byte_valid;  assign i0.byte_data = byte_data;
   assign i1.byte_valid = byte_valid;  assign i1.byte_data = byte_data;
   assign i2.byte_valid = byte_valid;  assign i2.byte_data = byte_data;
   assign i3.byte_valid = byte_valid;  assign i3.byte_data = byte_data;

   imem_loader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(2)) u0 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(i0.master),
      .cpu_hold(hold_v[0]), .busy(busy_v[0]), .done(done_v[0]), .words_loaded(wl_v[0]));
   imem_loader #(.BASE_ADDR(32'h0000_0000), .NUM_WORDS(4)) u1 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(i1.master),
      .cpu_hold(hold_v[1]), .busy(busy_v[1]), .done(done_v[1]), .words_loaded(wl_v[1]));
   imem_loader #(.BASE_ADDR(32'h0000_0100), .NUM_WORDS(2)) u2 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(i2.master),
      .cpu_hold(hold_v[2]), .busy(busy_v[2]), .done(done_v[2]), .words_loaded(wl_v[2]));
   imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .NUM_WORDS(2)) u3 (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(i3.master),
      .cpu_hold(hold_v[3]), .busy(busy_v[3]), .done(done_v[3]), .words_loaded(wl_v[3]));

   always #5 clk = ~clk;

   int          sel = 0;
   logic        s_ready, s_wr_en, s_hold, s_busy, s_done;
   logic [31:0] s_wr_addr, s_wr_data;
   logic [15:0] s_wl;

   // View of the DUT under test.
   always_comb begin
      s_hold = hold_v[sel];
      s_busy = busy_v[sel];
      s_done = done_v[sel];
      s_wl   = wl_v[sel];
      case (sel)
         1:       begin s_ready = i1.byte_ready; s_wr_en = i1.wr_en; s_wr_addr = i1.wr_addr; s_wr_data = i1.wr_data; end
         2:       begin s_ready = i2.byte_ready; s_wr_en = i2.wr_en; s_wr_addr = i2.wr_addr; s_wr_data = i2.wr_data; end
         3:       begin s_ready = i3.byte_ready; s_wr_en = i3.wr_en; s_wr_addr = i3.wr_addr; s_wr_data = i3.wr_data; end
         default: begin s_ready = i0.byte_ready; s_wr_en = i0.wr_en; s_wr_addr = i0.wr_addr; s_wr_data = i0.wr_data; end
      endcase
   end

   logic [31:0] qa [$];
   logic [31:0] qd [$];

   always @(negedge clk) begin
      if (s_wr_en === 1'b1) begin
         qa.push_back(s_wr_addr);
         qd.push_back(s_wr_data);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic do_reset();
      rstn = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      int   n;
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      do begin
         rdy = s_ready;
         @(posedge clk); #1;
         n++;
      end while (!rdy && n < 20);
      if (!rdy) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: byte %h never accepted", b);
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (s_done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (s_done !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: done still %b", s_done);
      end
   endtask

   task automatic test_reset();
      sel = 0;
      rstn = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      @(posedge clk); #1;
      n_checks++; if (s_busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b want 0", s_busy); end
      n_checks++; if (s_done !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b want 0", s_done); end
      n_checks++; if (s_hold !== 1'b0)   begin n_fail++; $display("FAIL rst_hold: got %b want 0", s_hold); end
      n_checks++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_ready: got %b want 0", s_ready); end
      n_checks++; if (s_wr_en !== 1'b0)  begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", s_wr_en); end
      n_checks++; if (s_wr_addr !== 32'h0 || s_wr_data !== 32'h0)
         begin n_fail++; $display("FAIL rst_wr_bus: got %h/%h want 0/0", s_wr_addr, s_wr_data); end
      n_checks++; if (s_wl !== 16'd0)    begin n_fail++; $display("FAIL rst_wl: got %0d want 0", s_wl); end
      #1 rstn = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_checks++; if (s_busy !== 1'b0)   begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", s_busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      int base;
      sel = 0;
      do_reset();
      base = qa.size();
      pulse_start();
      n_checks++; if (s_busy !== 1'b1 || s_hold !== 1'b1 || s_ready !== 1'b1)
         begin n_fail++; $display("FAIL b2b_load_flags: got busy=%b hold=%b ready=%b want 1/1/1", s_busy, s_hold, s_ready); end
      for (int i = 0; i < 4; i++) send_byte(bytes[i]);
      n_checks++; if (s_wr_en !== 1'b1 || s_wr_addr !== 32'h0 || s_wr_data !== 32'h0000_0013 || s_ready !== 1'b0)
         begin n_fail++; $display("FAIL b2b_write0: got en=%b addr=%h data=%h ready=%b want 1/0/00000013/0", s_wr_en, s_wr_addr, s_wr_data, s_ready); end
      n_checks++; if (s_wl !== 16'd0) begin n_fail++; $display("FAIL b2b_wl_in_write: got %0d want 0", s_wl); end
      for (int i = 4; i < 8; i++) send_byte(bytes[i]);
      wait_done();
      n_checks++; if (qa.size() - base !== 2) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 2", qa.size() - base); end
      else begin
         n_checks++; if (qa[base] !== 32'h0 || qd[base] !== 32'h0000_0013)
            begin n_fail++; $display("FAIL b2b_w0: got %h/%h want 00000000/00000013", qa[base], qd[base]); end
         n_checks++; if (qa[base+1] !== 32'h4 || qd[base+1] !== 32'h0010_0093)
            begin n_fail++; $display("FAIL b2b_w1: got %h/%h want 00000004/00100093", qa[base+1], qd[base+1]); end
      end
      n_checks++; if (s_done !== 1'b1 || s_wl !== 16'd2 || s_hold !== 1'b0 || s_busy !== 1'b0)
         begin n_fail++; $display("FAIL b2b_final: got done=%b wl=%0d hold=%b busy=%b want 1/2/0/0", s_done, s_wl, s_hold, s_busy); end
      n_checks++; if (s_wr_en !== 1'b0 || s_wr_addr !== 32'h4 || s_wr_data !== 32'h0010_0093)
         begin n_fail++; $display("FAIL b2b_bus_hold: got en=%b addr=%h data=%h want 0/4/00100093", s_wr_en, s_wr_addr, s_wr_data); end
   endtask

   task automatic test_gaps();
      logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      int base;
      int gap_bad;
      sel = 0;
      do_reset();
      base = qa.size();
      gap_bad = 0;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes[i]);
         for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            if (!s_wr_en && !s_done && s_ready !== 1'b1) gap_bad++;
         end
      end
      wait_done();
      n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL gap_ready: got %0d low cycles want 0", gap_bad); end
      n_checks++; if (qa.size() - base !== 2) begin n_fail++; $display("FAIL gap_nwrites: got %0d want 2", qa.size() - base); end
      else begin
         n_checks++; if (qa[base] !== 32'h0 || qd[base] !== 32'h0000_0013 || qa[base+1] !== 32'h4 || qd[base+1] !== 32'h0010_0093)
            begin n_fail++; $display("FAIL gap_writes: got %h/%h %h/%h want 0/00000013 4/00100093", qa[base], qd[base], qa[base+1], qd[base+1]); end
      end
      n_checks++; if (s_wl !== 16'd2) begin n_fail++; $display("FAIL gap_wl: got %0d want 2", s_wl); end
   endtask

   task automatic test_abort();
      int base;
      sel = 1;
      do_reset();
      base = qa.size();
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++; if (qa.size() - base !== 1) begin n_fail++; $display("FAIL abort_nwrites: got %0d want 1", qa.size() - base); end
      else begin
         n_checks++; if (qa[base] !== 32'h0 || qd[base] !== 32'hA3A2_A1A0)
            begin n_fail++; $display("FAIL abort_w0: got %h/%h want 00000000/a3a2a1a0", qa[base], qd[base]); end
      end
      n_checks++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_hold !== 1'b0 || s_ready !== 1'b0)
         begin n_fail++; $display("FAIL abort_flags: got busy=%b done=%b hold=%b ready=%b want 0/0/0/0", s_busy, s_done, s_hold, s_ready); end
      n_checks++; if (s_wl !== 16'd1) begin n_fail++; $display("FAIL abort_wl: got %0d want 1", s_wl); end
   endtask

   task automatic test_reset_midload();
      int base;
      sel = 1;
      do_reset();
      base = qa.size();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
      #1 rstn = 1'b0;
      #1;
      n_checks++; if (s_busy !== 1'b0 || s_hold !== 1'b0 || s_ready !== 1'b0 || s_wr_en !== 1'b0)
         begin n_fail++; $display("FAIL mrst_flags: got busy=%b hold=%b ready=%b en=%b want 0/0/0/0", s_busy, s_hold, s_ready, s_wr_en); end
      n_checks++; if (s_wr_addr !== 32'h0 || s_wr_data !== 32'h0 || s_wl !== 16'd0)
         begin n_fail++; $display("FAIL mrst_regs: got addr=%h data=%h wl=%0d want 0/0/0", s_wr_addr, s_wr_data, s_wl); end
      rstn = 1'b1;
      repeat (6) @(posedge clk); #1;
      n_checks++; if (qa.size() - base !== 2 || s_busy !== 1'b0)
         begin n_fail++; $display("FAIL mrst_partial: got writes=%0d busy=%b want 2/0", qa.size() - base, s_busy); end
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
      n_checks++; if (s_wr_en !== 1'b1 || s_wr_addr !== 32'h0 || s_wr_data !== 32'hC3C2_C1C0)
         begin n_fail++; $display("FAIL mrst_restart: got en=%b addr=%h data=%h want 1/0/c3c2c1c0", s_wr_en, s_wr_addr, s_wr_data); end
   endtask

   task automatic test_start_ignored();
      int base;
      sel = 2;
      do_reset();
      base = qa.size();
      pulse_start();
      send_byte(8'h01); send_byte(8'h02);
      pulse_start();
      n_checks++; if (s_busy !== 1'b1 || s_wl !== 16'd0)
         begin n_fail++; $display("FAIL restart_in_load: got busy=%b wl=%0d want 1/0", s_busy, s_wl); end
      for (int i = 3; i <= 8; i++) send_byte(8'(i));
      wait_done();
      n_checks++; if (qa.size() - base !== 2) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 2", qa.size() - base); end
      else begin
         n_checks++; if (qa[base] !== 32'h100 || qd[base] !== 32'h0403_0201 || qa[base+1] !== 32'h104 || qd[base+1] !== 32'h0807_0605)
            begin n_fail++; $display("FAIL restart_writes: got %h/%h %h/%h want 100/04030201 104/08070605", qa[base], qd[base], qa[base+1], qd[base+1]); end
      end
      pulse_start();
      n_checks++; if (s_done !== 1'b0 || s_wl !== 16'd0 || s_busy !== 1'b1)
         begin n_fail++; $display("FAIL restart_from_done: got done=%b wl=%0d busy=%b want 0/0/1", s_done, s_wl, s_busy); end
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      n_checks++; if (s_wr_en !== 1'b1 || s_wr_addr !== 32'h100 || s_wr_data !== 32'hDDCC_BBAA)
         begin n_fail++; $display("FAIL restart_rewrite: got en=%b addr=%h data=%h want 1/100/ddccbbaa", s_wr_en, s_wr_addr, s_wr_data); end
      @(posedge clk); #1;
      n_checks++; if (s_wl !== 16'd1) begin n_fail++; $display("FAIL restart_wl: got %0d want 1", s_wl); end
   endtask

   task automatic test_wrap();
      logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      int base;
      sel = 3;
      do_reset();
      base = qa.size();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(bytes[i]);
      wait_done();
      n_checks++; if (qa.size() - base !== 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 2", qa.size() - base); end
      else begin
         n_checks++; if (qa[base] !== 32'hFFFF_FFFC || qd[base] !== 32'h4433_2211)
            begin n_fail++; $display("FAIL wrap_w0: got %h/%h want fffffffc/44332211", qa[base], qd[base]); end
         n_checks++; if (qa[base+1] !== 32'h0 || qd[base+1] !== 32'h8877_6655)
            begin n_fail++; $display("FAIL wrap_w1: got %h/%h want 00000000/88776655", qa[base+1], qd[base+1]); end
      end
      n_checks++; if (s_done !== 1'b1 || s_wl !== 16'd2)
         begin n_fail++; $display("FAIL wrap_final: got done=%b wl=%0d want 1/2", s_done, s_wl); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_abort();
      test_reset_midload();
      test_start_ignored();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter NUM_WORDS, default 256: number of 32-bit words per load; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a load; sampled in IDLE and DONE only.
REQ-006 abort  input  1  cancels a load in progress.
REQ-007 byte_valid  input  1  byte_data is valid this cycle.
REQ-008 byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 wr_addr  output  32  instruction-memory byte address of the write.
REQ-012 wr_data  output  32  instruction word to write.
REQ-013 cpu_hold  output  1  holds the PC and fetch path while memory is being rewritten.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  last load completed all NUM_WORDS words.
REQ-016 words_loaded  output  16  count of words written in the current or last load.

Function
REQ-017 States: IDLE, LOAD, WRITE, DONE; encoding is free.
REQ-018 IDLE -> LOAD when start=1; word index, byte count and words_loaded clear to 0 on that edge.
REQ-019 DONE -> LOAD when start=1; done falls on that edge; counters clear as in REQ-018.
REQ-020 start in LOAD or WRITE is ignored.
REQ-021 byte_ready=1 in LOAD only; a byte transfers on any edge where byte_valid=1 and byte_ready=1.
REQ-022 Byte k of a word (k=0..3) lands in bits [8k+7:8k] of the assembly register; a stall (byte_valid=0) holds all state.
REQ-023 On the 4th accepted byte, the loader enters WRITE on the next edge.
REQ-024 WRITE lasts exactly one cycle: wr_en=1, wr_addr=BASE_ADDR+4*index, wr_data=assembled word, byte_ready=0.
REQ-025 words_loaded increments on the WRITE cycle edge; index arithmetic is 16-bit, address arithmetic is 32-bit and wraps modulo 2^32.
REQ-026 After WRITE: go to DONE if words_loaded has reached NUM_WORDS, otherwise go to LOAD with byte count 0.
REQ-027 wr_en=0 in every state except WRITE; wr_addr and wr_data hold their last values when wr_en=0.
REQ-028 cpu_hold=1 and busy=1 in LOAD and WRITE; both are 0 in IDLE and DONE.
REQ-029 done=1 in DONE only.
REQ-030 abort=1 in LOAD or WRITE goes to IDLE on the next edge; done stays 0; a WRITE cycle coinciding with abort still completes its write; a partial word is discarded.
REQ-031 abort has priority over start and byte transfers; abort in IDLE or DONE has no effect.
REQ-032 Throughput: at most one word per 5 cycles (4 byte cycles + 1 WRITE).

Reset
REQ-033 rstn=0 forces IDLE immediately, regardless of clk; all outputs go to 0, including wr_addr, wr_data and words_loaded.
REQ-034 rstn asserted mid-load discards all progress; no wr_en pulse occurs while rstn=0; after release the block waits for start.

Verification
REQ-035 NUM_WORDS=2, BASE_ADDR=0, start, bytes 13 00 00 00 93 00 10 00 back-to-back -> wr_en at 0x0 data 0x00000013, then at 0x4 data 0x00100093; then done=1, words_loaded=2, cpu_hold=0.
REQ-036 Bytes with byte_valid gaps of 3 cycles between each -> identical writes; byte_ready stays 1 across the gaps; no extra wr_en.
REQ-037 abort after 6 bytes (NUM_WORDS=4) -> exactly one write (addr 0x0); IDLE; busy=0, done=0, words_loaded=1.
REQ-038 rstn low for 1 ns between clock edges during the 3rd word -> outputs 0 at once; no write for the partial word; the next start restarts at BASE_ADDR.
REQ-039 start during LOAD, then start in DONE, with BASE_ADDR=32'h0000_0100 -> the first start is ignored; the second load rewrites from 0x100 with words_loaded restarting at 0.
REQ-040 BASE_ADDR=32'hFFFF_FFFC, NUM_WORDS=2 -> writes at 0xFFFFFFFC, then 0x00000000.
